// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared block width, words-per-block helper and serializer FSM state type
package aes_stream_pkg;
  localparam int AES_BLK_W = 128;
  typedef enum logic [0:0] {ST_IDLE, ST_SEND} ser_state_t;
  function automatic int words_per_blk(input int w);
    return AES_BLK_W / w;
  endfunction
endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: DEPTH x 128-bit block buffer with same-cycle push+pop (sync active-low rst)
module aes_blk_fifo
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AES_BLK_W-1:0] din,
  output logic [AES_BLK_W-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic                 one
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [AES_BLK_W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[tail] <= din;
  assign dout  = mem[head];
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign one   = cnt == CW'(1);
endmodule

// File: rtl/aes_text_out_serializer.sv
// aes_text_out_serializer: buffers AES text_out blocks on done_i and streams them MSB word first
// ports: clk, rst (sync active-low), done_i/text_out_i in; out_valid/out_ready/out_data/out_last
// stream; ovf_o sticky drop flag; out_par (even parity) only when AES_OUT_PARITY_EN is defined
module aes_text_out_serializer
  import aes_stream_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done_i,
  input  logic [AES_BLK_W-1:0] text_out_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_last,
`ifdef AES_OUT_PARITY_EN
  output logic                 out_par,
`endif
  output logic                 ovf_o
);
  localparam int N  = words_per_blk(WORD_W);
  localparam int IW = $clog2(N);
  ser_state_t state;
  logic [IW-1:0] idx;
  logic [AES_BLK_W-1:0] head, shifted;
  logic full, empty, one, hs, pop_blk, push;
  assign out_valid = state == ST_SEND;
  assign hs        = out_valid & out_ready;
  assign out_last  = out_valid & (idx == IW'(N - 1));
  assign pop_blk   = hs & out_last;
  assign push      = done_i & (!full | pop_blk);
  assign shifted   = head << (idx * WORD_W);
  assign out_data  = out_valid ? shifted[AES_BLK_W-1 -: WORD_W] : '0;
`ifdef AES_OUT_PARITY_EN
  assign out_par = ^out_data;
`endif
  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop_blk),
    .din  (text_out_i),
    .dout (head),
    .full (full),
    .empty(empty),
    .one  (one)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (hs) idx <= out_last ? '0 : idx + 1'b1;
      if (done_i & full & !pop_blk) ovf_o <= 1'b1;
      state <= state == ST_IDLE ? ((push | !empty) ? ST_SEND : ST_IDLE)
                                : ((pop_blk & one & !push) ? ST_IDLE : ST_SEND);
    end
  end
endmodule

// File: tb/tb_aes_text_out_serializer.sv
// tb_aes_text_out_serializer: directed self-checking bench for the AES text_out serializer
module tb_aes_text_out_serializer;
  localparam logic [3:0][31:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [3:0][31:0] B2 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
  localparam logic [3:0][31:0] B3 = 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000;
  localparam logic [127:0]     B6 = 128'h0102030405060708090A0B0C0D0E0F10;
  logic clk = 0, rst = 0, done_i = 0, out_ready = 1, done8 = 0, ready8 = 1;
  logic [127:0] text = '0, text8 = '0;
  logic valid32, last32, ovf32, valid8, last8, ovf8;
  logic [31:0] data32;
  logic [7:0] data8;
`ifdef AES_OUT_PARITY_EN
  logic par32, par8;
`endif
  int npass = 0, nfail = 0, ntot = 0;
  always #5 clk = ~clk;
  aes_text_out_serializer #(.WORD_W(32), .DEPTH(2)) u32 (
    .clk(clk), .rst(rst), .done_i(done_i), .text_out_i(text),
    .out_valid(valid32), .out_ready(out_ready), .out_data(data32), .out_last(last32),
`ifdef AES_OUT_PARITY_EN
    .out_par(par32),
`endif
    .ovf_o(ovf32)
  );
  aes_text_out_serializer #(.WORD_W(8), .DEPTH(2)) u8 (
    .clk(clk), .rst(rst), .done_i(done8), .text_out_i(text8),
    .out_valid(valid8), .out_ready(ready8), .out_data(data8), .out_last(last8),
`ifdef AES_OUT_PARITY_EN
    .out_par(par8),
`endif
    .ovf_o(ovf8)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_blk(input string tag, input logic [3:0][31:0] b);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_valid"}, valid32, 1'b1);
      chk({tag, "_data"}, data32, b[3-k]);
      chk({tag, "_last"}, last32, k == 3);
      step();
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", valid32, 0);
    chk("rst_data", data32, 0);
    chk("rst_last", last32, 0);
    chk("rst_ovf", ovf32, 0);
    chk("rst_valid8", valid8, 0);
    chk("rst_data8", data8, 0);
    rst = 1;
    step();
    chk("idle_valid", valid32, 0);
    text = B1; done_i = 1;
    step();
    done_i = 0;
    expect_blk("t1", B1);
    chk("t1_idle", valid32, 0);
    text = B1; done_i = 1;
    step();
    done_i = 0;
    chk("t2_w0", data32, 32'h00112233);
    step();
    chk("t2_w1", data32, 32'h44556677);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_data", data32, 32'h44556677);
      chk("t2_hold_valid", valid32, 1);
      chk("t2_hold_last", last32, 0);
`ifdef AES_OUT_PARITY_EN
      chk("t2_hold_par", par32, 1'b0);
`endif
    end
    out_ready = 1;
    step();
    chk("t2_w2", data32, 32'h8899AABB);
    step();
    chk("t2_w3", data32, 32'hCCDDEEFF);
    chk("t2_w3_last", last32, 1);
    step();
    chk("t2_idle", valid32, 0);
    out_ready = 0;
    text = B1; done_i = 1;
    step();
    text = B2;
    step();
    text = B3;
    step();
    done_i = 0;
    chk("t3_ovf", ovf32, 1);
    chk("t3_valid", valid32, 1);
    chk("t3_head", data32, 32'h00112233);
    step();
    step();
    chk("t3_ovf_sticky", ovf32, 1);
    out_ready = 1;
    expect_blk("t3_b1", B1);
    expect_blk("t3_b2", B2);
    chk("t3_idle", valid32, 0);
    chk("t3_ovf_end", ovf32, 1);
    rst = 0;
    step();
    rst = 1;
    chk("t3_ovf_clr", ovf32, 0);
    out_ready = 0;
    text = B1; done_i = 1;
    step();
    text = B2;
    step();
    done_i = 0;
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_b1_data", data32, B1[3-k]);
      step();
    end
    chk("t4_b1_w3", data32, 32'hCCDDEEFF);
    chk("t4_b1_last", last32, 1);
    text = B3; done_i = 1;
    step();
    done_i = 0;
    chk("t4_ovf", ovf32, 0);
    expect_blk("t4_b2", B2);
    expect_blk("t4_b3", B3);
    chk("t4_idle", valid32, 0);
    text = B1; done_i = 1;
    step();
    done_i = 0;
    step();
    step();
    chk("t5_w2", data32, 32'h8899AABB);
    rst = 0;
    step();
    chk("t5_rst_valid", valid32, 0);
    chk("t5_rst_data", data32, 0);
    chk("t5_rst_last", last32, 0);
    chk("t5_rst_ovf", ovf32, 0);
    rst = 1;
    step();
    chk("t5_empty", valid32, 0);
    text = B2; done_i = 1;
    step();
    done_i = 0;
    expect_blk("t5_b2", B2);
    chk("t5_idle", valid32, 0);
    text8 = B6; done8 = 1;
    step();
    done8 = 0;
    for (int k = 0; k < 16; k++) begin
      chk("t6_valid", valid8, 1);
      chk("t6_data", data8, 8'(k + 1));
      chk("t6_last", last8, k == 15);
`ifdef AES_OUT_PARITY_EN
      chk("t6_par", par8, 1'($countones(k + 1) % 2));
`endif
      step();
    end
    chk("t6_idle", valid8, 0);
    chk("t6_ovf", ovf8, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
